// File: rtl/chacha_stream_gen.sv
// chacha_stream_gen: multi-block ChaCha8/12/20 keystream generator, one round per cycle.
// Define CHACHA_ZEROIZE_EN to blank keystream while not valid and wipe key/nonce/working state on done.
module chacha_stream_gen #(
    parameter int ROUNDS = 20,
    parameter int NB_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [255:0]    key,
    input  logic [31:0]     counter,
    input  logic [95:0]     nonce,
    input  logic [NB_W-1:0] num_blocks,
    output logic            busy,
    output logic [511:0]    keystream,
    output logic            ks_valid,
    input  logic            ks_ready,
    output logic [NB_W-1:0] blk_idx,
    output logic            done,
    output logic            ctr_wrap
);
    if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
        $error("chacha_stream_gen: ROUNDS must be 8, 12 or 20");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;
    state_t state, nstate;

    logic [255:0]      key_q;
    logic [95:0]       nonce_q;
    logic [31:0]       ctr_q;
    logic [NB_W-1:0]   nb_q;
    logic [4:0]        rcnt;
    logic [15:0][31:0] ws, in_st, reload, nxt, sum;
    logic [511:0]      ks_q;
    logic [127:0]      qo;
    logic              last;
    int                dg;

    function automatic logic [511:0] init_state(input logic [255:0] k, input logic [31:0] c,
                                                input logic [95:0] n);
        return {n, c, k, 128'h6b206574_79622d32_3320646e_61707865};
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a0, input logic [31:0] b0,
                                        input logic [31:0] c0, input logic [31:0] d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    // input state is rebuilt from the latched request rather than stored separately
    assign in_st  = init_state(key_q, ctr_q, nonce_q);
    assign reload = init_state(key_q, ctr_q + 32'd1, nonce_q);
    assign last   = blk_idx == nb_q - 1'b1;
    assign busy   = state != IDLE;

    // odd rounds rotate lanes b/c/d by 1/2/3 to form the diagonals
    always_comb begin
        nxt = ws;
        qo  = '0;
        dg  = rcnt[0] ? 1 : 0;
        for (int q = 0; q < 4; q++) begin
            qo = qr(ws[q], ws[4 + ((q + dg) % 4)], ws[8 + ((q + 2 * dg) % 4)], ws[12 + ((q + 3 * dg) % 4)]);
            nxt[q]                        = qo[31:0];
            nxt[4 + ((q + dg) % 4)]       = qo[63:32];
            nxt[8 + ((q + 2 * dg) % 4)]   = qo[95:64];
            nxt[12 + ((q + 3 * dg) % 4)]  = qo[127:96];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 16; i++) sum[i] = ws[i] + in_st[i];
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = (start && num_blocks != '0) ? ROUND : IDLE;
            ROUND:   nstate = (rcnt == 5'(ROUNDS - 1)) ? FINAL : ROUND;
            FINAL:   nstate = OUT;
            OUT:     nstate = ks_ready ? (last ? IDLE : ROUND) : OUT;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q    <= '0;
            nonce_q  <= '0;
            ctr_q    <= '0;
            nb_q     <= '0;
            rcnt     <= '0;
            ws       <= '0;
            ks_q     <= '0;
            ks_valid <= 1'b0;
            blk_idx  <= '0;
            done     <= 1'b0;
            ctr_wrap <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && num_blocks != '0) begin
                        key_q    <= key;
                        nonce_q  <= nonce;
                        ctr_q    <= counter;
                        nb_q     <= num_blocks;
                        ws       <= init_state(key, counter, nonce);
                        rcnt     <= '0;
                        blk_idx  <= '0;
                        ctr_wrap <= 1'b0;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                ROUND: begin
                    ws   <= nxt;
                    rcnt <= rcnt + 5'd1;
                end
                FINAL: begin
                    ks_q     <= sum;
                    ks_valid <= 1'b1;
                end
                OUT: begin
                    if (ks_ready) begin
                        ks_valid <= 1'b0;
                        if (last) begin
                            done <= 1'b1;
`ifdef CHACHA_ZEROIZE_EN
                            key_q   <= '0;
                            nonce_q <= '0;
                            ws      <= '0;
`endif
                        end else begin
                            ctr_q    <= ctr_q + 32'd1;
                            ctr_wrap <= ctr_wrap | (&ctr_q);
                            blk_idx  <= blk_idx + 1'b1;
                            ws       <= reload;
                            rcnt     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHACHA_ZEROIZE_EN
    assign keystream = ks_valid ? ks_q : '0;
`else
    assign keystream = ks_q;
`endif
endmodule

// File: tb/tb_chacha_stream_gen.sv
// tb_chacha_stream_gen: checks chacha_stream_gen against a software ChaCha block model.
// Covers RFC 8439 vector, multi-block backpressure, counter wrap, zero blocks, ignored start and reset abort.
module tb_chacha_stream_gen;
    localparam int NB_W = 8;

    logic            clk = 0, reset = 0, start = 0, ks_ready = 0;
    logic [255:0]    key = '0;
    logic [31:0]     counter = '0;
    logic [95:0]     nonce = '0;
    logic [NB_W-1:0] num_blocks = '0;
    logic            busy, ks_valid, done, ctr_wrap;
    logic [511:0]    keystream;
    logic [NB_W-1:0] blk_idx;
    logic            b8, v8, d8, w8, b12, v12, d12, w12;
    logic [511:0]    k8, k12;
    logic [NB_W-1:0] i8, i12;

    chacha_stream_gen #(.ROUNDS(20), .NB_W(NB_W)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .counter(counter), .nonce(nonce),
        .num_blocks(num_blocks), .busy(busy), .keystream(keystream), .ks_valid(ks_valid),
        .ks_ready(ks_ready), .blk_idx(blk_idx), .done(done), .ctr_wrap(ctr_wrap));
    chacha_stream_gen #(.ROUNDS(8), .NB_W(NB_W)) dut8 (
        .clk(clk), .reset(reset), .start(start), .key(key), .counter(counter), .nonce(nonce),
        .num_blocks(num_blocks), .busy(b8), .keystream(k8), .ks_valid(v8),
        .ks_ready(1'b1), .blk_idx(i8), .done(d8), .ctr_wrap(w8));
    chacha_stream_gen #(.ROUNDS(12), .NB_W(NB_W)) dut12 (
        .clk(clk), .reset(reset), .start(start), .key(key), .counter(counter), .nonce(nonce),
        .num_blocks(num_blocks), .busy(b12), .keystream(k12), .ks_valid(v12),
        .ks_ready(1'b1), .blk_idx(i12), .done(d12), .ctr_wrap(w12));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           tests = 0, fails = 0;
    logic [255:0] rfc_key, exp_key;
    logic [95:0]  rfc_nonce, exp_nonce;
    logic [31:0]  exp_ctr;
    int           s_cyc, idx, n_hs, n_done, rise_last, rise_prev, r8, r12;
    logic         prev_v, pv8, pv12;
    logic [511:0] ks_rise, ks8, ks12, m;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [31:0] c,
                                                  input logic [95:0] n, input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [31:0] a, b, cc, d;
        int t [8][4];
        int row;
        logic [511:0] res;
        t = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
              '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32 * i +: 32];
        x = s;
        for (int r = 0; r < rounds; r++) begin
            for (int q = 0; q < 4; q++) begin
                row = (r % 2) * 4 + q;
                a = x[t[row][0]]; b = x[t[row][1]]; cc = x[t[row][2]]; d = x[t[row][3]];
                a = a + b;  d = rotl(d ^ a, 16);
                cc = cc + d; b = rotl(b ^ cc, 12);
                a = a + b;  d = rotl(d ^ a, 8);
                cc = cc + d; b = rotl(b ^ cc, 7);
                x[t[row][0]] = a; x[t[row][1]] = b; x[t[row][2]] = cc; x[t[row][3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) res[32 * i +: 32] = x[i] + s[i];
        return res;
    endfunction

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!busy) idx = 0;
            if (ks_valid) begin
                check("keystream", keystream, chacha_block(exp_key, exp_ctr + 32'(idx), exp_nonce, 20));
                check("blk_idx", blk_idx, idx);
                check("ctr_wrap", ctr_wrap, (64'(exp_ctr) + 64'(idx)) > 64'hFFFF_FFFF);
                if (!prev_v) begin
                    rise_prev = rise_last;
                    rise_last = cyc;
                    ks_rise   = keystream;
                end
                if (ks_ready) begin
                    n_hs++;
                    idx++;
                end
            end
            if (done) n_done++;
            prev_v = ks_valid;
            if (v8 && !pv8) begin r8 = cyc; ks8 = k8; end
            if (v12 && !pv12) begin r12 = cyc; ks12 = k12; end
            pv8  = v8;
            pv12 = v12;
        end
    endtask

    task automatic go(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                      input logic [NB_W-1:0] nb);
        exp_key = k; exp_ctr = c; exp_nonce = n;
        @(posedge clk); #1;
        key = k; counter = c; nonce = n; num_blocks = nb; start = 1;
        s_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int bound, input bit tog);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #1;
            if (tog) ks_ready = ~ks_ready;
            seen = done;
        end
        check("done_within_bound", 640'(seen), 640'd1);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    int h0, d0;

    initial begin
        idx = 0; n_hs = 0; n_done = 0; rise_last = 0; rise_prev = 0; r8 = 0; r12 = 0;
        prev_v = 0; pv8 = 0; pv12 = 0; ks_rise = '0; ks8 = '0; ks12 = '0;
        exp_key = '0; exp_ctr = '0; exp_nonce = '0;
        for (int i = 0; i < 32; i++) rfc_key[8 * i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, ks_valid, done, ctr_wrap, blk_idx, keystream}, '0);
        m = chacha_block(rfc_key, 32'd1, rfc_nonce, 20);
        check("model_w0", m[31:0], 32'he4e7f110);
        check("model_w1", m[63:32], 32'h15593bd1);
        check("model_w15", m[511:480], 32'h4e3c50a2);
        reset = 1;
        ks_ready = 1;

        // RFC 8439 single block, plus the ChaCha8/12 instances on the same request
        h0 = n_hs; d0 = n_done;
        go(rfc_key, 32'd1, rfc_nonce, 1);
        wait_done(40, 0);
        settle();
        check("t1_latency", rise_last - s_cyc, 21);
        check("t1_w0", ks_rise[31:0], 32'he4e7f110);
        check("t1_w1", ks_rise[63:32], 32'h15593bd1);
        check("t1_w15", ks_rise[511:480], 32'h4e3c50a2);
        check("t1_blocks", n_hs - h0, 1);
        check("t1_done_count", n_done - d0, 1);
        check("t1_ctr_wrap", ctr_wrap, 0);
        check("t1_busy_after", busy, 0);
        check("r8_latency", r8 - s_cyc, 9);
        check("r8_block", ks8, chacha_block(rfc_key, 32'd1, rfc_nonce, 8));
        check("r12_latency", r12 - s_cyc, 13);
        check("r12_block", ks12, chacha_block(rfc_key, 32'd1, rfc_nonce, 12));

        // three blocks with toggling ready
        ks_ready = 0;
        h0 = n_hs; d0 = n_done;
        go(rfc_key, 32'd1, rfc_nonce, 3);
        wait_done(200, 1);
        ks_ready = 1;
        settle();
        check("t2_blocks", n_hs - h0, 3);
        check("t2_done_count", n_done - d0, 1);

        // counter wrap
        h0 = n_hs;
        go(rfc_key, 32'hFFFF_FFFF, rfc_nonce, 2);
        wait_done(100, 0);
        settle();
        check("t3_blocks", n_hs - h0, 2);
        check("t3_throughput", rise_last - rise_prev, 22);
        check("t3_ctr_wrap_sticky", ctr_wrap, 1);

        // zero-block request
        h0 = n_hs; d0 = n_done;
        go(rfc_key, 32'd1, rfc_nonce, 0);
        check("t4_done_pulse", done, 1);
        check("t4_busy", busy, 0);
        @(posedge clk); #1;
        check("t4_done_one_cycle", done, 0);
        check("t4_ctr_wrap_kept", ctr_wrap, 1);
        settle();
        check("t4_no_blocks", n_hs - h0, 0);
        check("t4_done_count", n_done - d0, 1);

        // start while busy is ignored
        h0 = n_hs; d0 = n_done;
        go(rfc_key, 32'd5, rfc_nonce, 1);
        repeat (5) @(posedge clk);
        #1;
        key = {8{32'hAAAA_AAAA}}; counter = 32'd0; nonce = '1; num_blocks = 2; start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_done(60, 0);
        repeat (30) @(posedge clk);
        #1;
        check("t5_blocks", n_hs - h0, 1);
        check("t5_done_count", n_done - d0, 1);
        check("t5_ctr_wrap_cleared", ctr_wrap, 0);

        // reset mid-request
        go(~rfc_key, 32'd7, rfc_nonce, 2);
        repeat (10) @(posedge clk);
        #1;
        check("t6_busy_before_reset", busy, 1);
        d0 = n_done;
        reset = 0;
        #1;
        check("t6_reset_outputs", {busy, ks_valid, done, ctr_wrap, blk_idx, keystream}, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_done", n_done - d0, 0);
        h0 = n_hs;
        go(rfc_key, 32'd1, rfc_nonce, 1);
        wait_done(40, 0);
        settle();
        check("t6_blocks", n_hs - h0, 1);
        check("t6_w0", ks_rise[31:0], 32'he4e7f110);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/chacha_stream_gen.md
Name: chacha_stream_gen

Overview:
Parametrised multi-block ChaCha keystream generator, successor to the single-block ChaCha20 top level. Accepts one key/nonce/starting counter plus a block count and emits that many consecutive 512-bit keystream blocks over a valid/ready stream, incrementing the block counter internally. Round count is selectable for ChaCha8/12/20. The round datapath is internal: four parallel quarter-rounds, one round per cycle. Sits between the key-management front end and the XOR/cipher datapath.

Parameters:
ROUNDS, 20, total rounds per block; legal values 8, 12, 20 (even), elaborate-time error otherwise
NB_W, 8, width of block-count input; max request is 2^NB_W-1 blocks

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
key  input  256  key; state word 4+i = key[32i+31:32i]
counter  input  32  initial block counter (state word 12)
nonce  input  96  nonce; state word 13+i = nonce[32i+31:32i]
num_blocks  input  NB_W  blocks to generate
busy  output  1  high from accepted start until done pulse
keystream  output  512  block; word i at [32i+31:32i]
ks_valid  output  1  keystream holds a valid block
ks_ready  input  1  downstream accepts block
blk_idx  output  NB_W  index of block on keystream, 0-based
done  output  1  one-cycle pulse, request complete
ctr_wrap  output  1  sticky: block counter wrapped 0xFFFFFFFF->0 during request

Behaviour:
- Reset (reset low, async): state IDLE; busy, ks_valid, done, ctr_wrap=0; keystream=0; blk_idx=0; internal key/nonce/counter registers=0.
- States: IDLE, ROUND, FINAL, OUT.
- IDLE: start=1 and num_blocks!=0 -> latch key, nonce, counter, num_blocks; load working and input state (constants 61707865,3320646e,79622d32,6b206574); round_cnt=0; busy=1; clear ctr_wrap; -> ROUND.
- IDLE: start=1 and num_blocks==0 -> no output; done pulses next cycle; busy stays 0.
- ROUND: one round per cycle; even round_cnt = column round, odd = diagonal round; QR = add/xor/rotl 16,12,8,7 mod 2^32. After ROUNDS cycles -> FINAL.
- FINAL: keystream <= working + input state (word-wise, mod 2^32); ks_valid<=1 -> OUT. First ks_valid at start-edge + ROUNDS + 1 cycles.
- OUT: keystream, blk_idx stable while ks_valid && !ks_ready. On ks_valid && ks_ready:
  - more blocks: ks_valid<=0, counter<=counter+1 (mod 2^32; 0xFFFFFFFF->0 sets ctr_wrap), blk_idx++, reload working state, -> ROUND. Per-block throughput ROUNDS+2 cycles.
  - last block: ks_valid<=0, done<=1 for one cycle, busy<=0, -> IDLE.
- start while busy: ignored, no effect on latched inputs.
- Input changes after acceptance: no effect.
- ks_ready held high continuously: no bubbles beyond the fixed per-block latency.
- reset low mid-request: immediate abort to reset values, no done pulse.

Optional Feature:
CHACHA_ZEROIZE_EN: defined -> keystream driven to 0 whenever ks_valid=0; key, nonce, and working-state registers cleared on the done pulse. Undefined -> keystream holds last block after handshake; registers retain contents until next start.

Test Plan:
- RFC 8439 2.3.2: key bytes 00..1f (word4=03020100), nonce words 09000000/4a000000/00000000, counter=1, num_blocks=1, ROUNDS=20, ks_ready=1 -> ks_valid at cycle 21; keystream[31:0]=e4e7f110, [63:32]=15593bd1, [511:480]=4e3c50a2; done next cycle; ctr_wrap=0.
- Same key/nonce, counter=1, num_blocks=3, ks_ready toggling 0/1 -> three blocks, blk_idx 0,1,2; block 1 equals single-block run with counter=2; keystream stable while ready=0; exactly one done.
- counter=FFFFFFFF, num_blocks=2 -> second block computed with counter=0; ctr_wrap=1 until next accepted start.
- num_blocks=0 with start -> no ks_valid; done pulses once; busy stays 0.
- start reasserted with different key mid-request, then reset low during ROUND -> first request unaffected by second start; reset returns all outputs to 0 within same cycle, no done; fresh start afterwards produces correct block.
- ROUNDS=8 and 12 builds -> ks_valid at cycle ROUNDS+1; output matches software ChaCha8/12 model for the RFC key/nonce.
